// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream constants for imem_loader
// Optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } imem_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - 2**ADDR_W x 32 instruction store, one synchronous write port, one asynchronous read port
// Contents are deliberately not reset so a partial reload keeps words beyond the new program.
module imem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream -> instruction RAM, holds the core in reset until loaded
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
    localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam imem_state_t DONE_STATE = CHK;
`else
    localparam imem_state_t DONE_STATE = RUN;
`endif

    imem_state_t       state, state_next;
    logic [7:0]        cnt_lo;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [15:0]       hdr_count;
    logic              accept;
    logic              too_big;
    logic              last_word;
    logic              wr_en;
    logic [31:0]       rdata;
    logic              pc_in_range;
    logic              unused_pc_bits;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    assign rx_ready  = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CHK);
    assign accept    = rx_valid && rx_ready;
    assign hdr_count = {rx_data, cnt_lo};
    assign too_big   = {1'b0, hdr_count} > MAX_WORDS;
    assign last_word = word_cnt == (n_words - (ADDR_W+1)'(1));
    assign wr_en     = (state == DATA) && accept && (byte_cnt == LAST_BYTE);

    always_comb begin
        state_next = state;
        case (state)
            HDR0: if (accept) state_next = HDR1;
            HDR1: begin
                if (accept) begin
                    if (too_big)             state_next = ERR;
                    else if (hdr_count == 0) state_next = DONE_STATE;
                    else                     state_next = DATA;
                end
            end
            DATA: if (wr_en && last_word) state_next = DONE_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) state_next = (rx_data == chk_acc) ? RUN : ERR;
            end
`endif
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HDR0;
        end else begin
            state <= state_next;
        end
    end

    // Bytes 0..2 of a word shift down so the 4th byte lands directly on top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_lo   <= '0;
            n_words  <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
        end else if (accept) begin
            if (state == HDR0) begin
                cnt_lo <= rx_data;
            end
            if (state == HDR1) begin
                n_words  <= hdr_count[ADDR_W:0];
                word_cnt <= '0;
                byte_cnt <= '0;
            end
            if (state == DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                word_buf <= {rx_data, word_buf[23:8]};
                if (byte_cnt == LAST_BYTE) begin
                    word_cnt <= word_cnt + (ADDR_W+1)'(1);
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_acc <= '0;
        end else if (accept && (state == DATA)) begin
            chk_acc <= chk_acc ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            cpu_reset  <= (state != RUN);
            load_done  <= (state == RUN);
            load_error <= (state == ERR);
        end
    end

    imem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (word_cnt[ADDR_W-1:0]),
        .wdata ({rx_data, word_buf}),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (rdata)
    );

    // Fetches outside the RAM window read as zero rather than aliasing.
    assign pc_in_range    = (pc[31:ADDR_W+2] == '0);
    assign instruction    = pc_in_range ? rdata : 32'h0;
    assign unused_pc_bits = ^pc[1:0];

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader (honours IMEM_LOADER_CHECKSUM_EN)
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int errors = 0;
    int checks = 0;

    imem_loader #(.ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .pc          (pc),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic read_pc(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        #1;
        check(tag, instruction, exp);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [7:0] prog [14] = '{8'h03, 8'h00,
                              8'h05, 8'h00, 8'hA0, 8'hE3,
                              8'h01, 8'h10, 8'h80, 8'hE2,
                              8'hFE, 8'hFF, 8'hFF, 8'hEA};

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_load_done", load_done, 0);
        check("rst_load_error", load_error, 0);
        check("rst_rx_ready", rx_ready, 1);
        reset = 1'b1;

        // Three-word program, back-to-back bytes.
        for (int i = 0; i < 14; i++) begin
            send_byte(prog[i], 0);
            if (i == 5) read_pc("first_word_visible", 32'h0, 32'hE3A00005);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("n3_chk_ready", rx_ready, 1);
        send_byte(8'h21, 0);
`endif
        check("n3_ready_drop", rx_ready, 0);
        check("n3_cpu_reset_hold", cpu_reset, 1);
        @(posedge clk);
        #1;
        check("n3_cpu_reset_fall", cpu_reset, 0);
        check("n3_load_done", load_done, 1);
        check("n3_load_error", load_error, 0);
        read_pc("n3_pc0", 32'h0, 32'hE3A00005);
        read_pc("n3_pc4", 32'h4, 32'hE2801001);
        read_pc("n3_pc8", 32'h8, 32'hEAFFFFFE);
        read_pc("n3_pc9_lowbits", 32'h9, 32'hEAFFFFFE);
        read_pc("n3_pc400", 32'h400, 32'h0);

        // Asynchronous reset takes effect before any clock edge.
        reset = 1'b0;
        #1;
        check("async_cpu_reset", cpu_reset, 1);
        check("async_load_done", load_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Same program with random valid gaps.
        for (int i = 0; i < 14; i++) send_byte(prog[i], $urandom_range(0, 3));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h21, $urandom_range(0, 3));
`endif
        check("gap_ready_drop", rx_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("gap_cpu_reset", cpu_reset, 0);
        check("gap_load_done", load_done, 1);
        read_pc("gap_pc0", 32'h0, 32'hE3A00005);
        read_pc("gap_pc4", 32'h4, 32'hE2801001);
        read_pc("gap_pc8", 32'h8, 32'hEAFFFFFE);

        // N=0: empty program.
        pulse_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        check("n0_ready_drop", rx_ready, 0);
        @(posedge clk);
        #1;
        check("n0_load_done", load_done, 1);
        check("n0_cpu_reset", cpu_reset, 0);

        // N=0x0100 is the largest legal count and enters DATA.
        pulse_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        @(posedge clk);
        #1;
        check("n256_ready", rx_ready, 1);
        check("n256_no_error", load_error, 0);

        // N=0x0101 exceeds the RAM.
        pulse_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("n257_ready", rx_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("n257_load_error", load_error, 1);
        check("n257_cpu_reset", cpu_reset, 1);
        check("n257_load_done", load_done, 0);

        // Reset mid-load, then a one-word program.
        pulse_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        read_pc("abort_partial_pc0", 32'h0, 32'hDDCCBBAA);
        pulse_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h08, 0);
`endif
        @(posedge clk);
        #1;
        check("abort_load_done", load_done, 1);
        read_pc("abort_pc0", 32'h0, 32'h12345678);
        read_pc("abort_pc4_kept", 32'h4, 32'hE2801001);
        read_pc("abort_pc8_kept", 32'h8, 32'hEAFFFFFE);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum accept and reject on word 01020304.
        pulse_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h03, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        @(posedge clk);
        #1;
        check("chk_good_done", load_done, 1);
        check("chk_good_error", load_error, 0);
        pulse_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h03, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h05, 0);
        @(posedge clk);
        #1;
        check("chk_bad_error", load_error, 1);
        check("chk_bad_cpu_reset", cpu_reset, 1);
        check("chk_bad_ready", rx_ready, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory for the single-cycle ARMv4 core: sits directly upstream of the processor, receives a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words into an internal instruction RAM, and holds the core in reset until the load completes. After the load it serves the core's `Instruction` bus combinationally from `PC`. A malformed header, or a checksum failure when enabled, parks the block in a sticky error state with the core still held in reset.

## Interface
- `ADDR_W`, 8: word-address width; RAM depth is `2**ADDR_W` words.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rx_valid` input 1: byte-stream valid.
- `rx_data` input 8: byte-stream data.
- `rx_ready` output 1: block accepts a byte on an edge where `rx_valid && rx_ready`.
- `pc` input 32: core program counter, byte address.
- `instruction` output 32: word at `pc`, combinational.
- `cpu_reset` output 1: active-high reset to the core, registered.
- `load_done` output 1: program loaded and core released, sticky.
- `load_error` output 1: load failed, sticky until `reset`.

## Operation
- Stream format: `CNT_LO`, `CNT_HI` (16-bit word count N, little-endian), then 4N data bytes with each word least-significant byte first. With `IMEM_LOADER_CHECKSUM_EN` defined, one trailing byte follows the data.
- FSM states: `HDR0`, `HDR1`, `DATA`, `CHK`, `RUN`, `ERR`.
  - `HDR0` -> `HDR1` on accept. Low byte is latched.
  - `HDR1` -> `ERR` if N > `2**ADDR_W`.
  - `HDR1` -> `RUN` (or `CHK` with the macro) if N == 0.
  - `HDR1` -> `DATA` otherwise.
  - `DATA`: 2-bit byte counter and `ADDR_W+1`-bit word counter. On the 4th byte of a word, that word is written to `mem[word_cnt]` and `word_cnt` increments. After word N-1 is written, go to `RUN` (or `CHK`).
  - `CHK`: the accepted byte is compared with the XOR of all data bytes. Match -> `RUN`; mismatch -> `ERR`.
  - `RUN`, `ERR`: terminal until `reset`.
- `rx_ready` = 1 in `HDR0`, `HDR1`, `DATA`, `CHK`; 0 in `RUN` and `ERR`. It is decoded from state, with no combinational path from `rx_valid`.
- `rx_valid` low stalls the FSM indefinitely. No timeout.
- Read path: `instruction = mem[pc[ADDR_W+1:2]]` when `pc[31:ADDR_W+2] == 0`, else `32'h0`. `pc[1:0]` is ignored. Reads are live during a load and return partially written contents.
- Words beyond N are not cleared; they keep their prior contents.
- Reset values: state `HDR0`, counters 0, checksum accumulator 0, `cpu_reset`=1, `load_done`=0, `load_error`=0. RAM contents are not reset.
- `reset` asserted mid-load aborts the load; the next stream starts from `HDR0`.

## Timing
- Byte acceptance has one-byte-per-cycle throughput.
- A word write is visible on `instruction` in the cycle after the edge accepting its 4th byte.
- `cpu_reset` falls and `load_done` rises on the edge after the edge that enters `RUN`. Both are registered from state.
- `load_error` rises on the edge after the edge that enters `ERR`.
- Read latency is 0 cycles (combinational), as the single-cycle core requires.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: `CHK` state and the 8-bit XOR accumulator exist. The trailing byte is required.
- Not defined: `CHK` and the accumulator are removed. `DATA` goes directly to `RUN`. No trailing byte is consumed.

## Structure
- `imem_loader_pkg` holds:
  - the state enum `imem_state_t`
  - the header byte count constant (2)
  - the `WORD_BYTES` constant (4)
- Sub-module `imem_ram`: a `2**ADDR_W` x 32 register array with one synchronous write port and one asynchronous read port. The FSM, counters, and word assembly live in `imem_loader`.

## Test plan
- N=3 stream with words `E3A00005`, `E2801001`, `EAFFFFFE`, sent with no gaps:
  - `rx_ready` drops after byte 14.
  - `cpu_reset` falls one cycle after that.
  - `pc`=0/4/8 reads back the three words.
  - `pc`=`0x400` reads 0.
- Same stream with random `rx_valid` gaps: identical memory image and identical final outputs.
- N=0: the loader enters `RUN` (or `CHK`) after 2 bytes; `load_done`=1 and `cpu_reset`=0.
- N=`0x0101` with `ADDR_W`=8: `ERR` is entered; `load_error`=1, `cpu_reset` stays 1, `rx_ready`=0.
- `reset` pulsed after 6 data bytes, then a full N=1 stream of `12345678`: `pc`=0 reads `12345678` and `load_done`=1.
- With the macro defined, N=1 word `01020304`:
  - trailing byte `04` gives `RUN`.
  - trailing byte `05` gives `ERR` with `cpu_reset` held at 1.
